ula_para_barramento: RTL

//  Write-side counterpart of the temp register. Queues ALU results and drives them onto the

---
 rtl/ula_para_barramento.sv | 102 ++++++++++
 1 files changed

// File: rtl/ula_para_barramento.sv
// Queues ALU results in a small FIFO and writes them onto the shared Data bus
// with the set-up / io-low / hold strobe sequence that the temp register latches on.
//
// state  | meaning
// -------+-----------------------------------------------------------
// OCIOSO | idle, bus released, io=1
// PEDE   | bus_req raised, waiting for bus_grant
// DIRIGE | Data = FIFO head, io=1 (set-up)
// STROBE | Data = FIFO head, io=0 (temp latches)
// LIBERA | Data = FIFO head, io=1 (hold); head popped on exit
module ula_para_barramento #(
    parameter int Tamanho_Da_Palavra = 16,
    parameter int PROFUNDIDADE       = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [Tamanho_Da_Palavra-1:0]     saidaUla,
    input  logic                              ula_valid,
    output logic                              ula_ready,
    output logic                              bus_req,
    input  logic                              bus_grant,
    inout  wire  [Tamanho_Da_Palavra-1:0]     Data,
    output logic                              io,
    output logic [$clog2(PROFUNDIDADE):0]     ocupacao,
    output logic                              vazio,
    output logic                              cheio
);
    localparam int W  = Tamanho_Da_Palavra;
    localparam int AW = $clog2(PROFUNDIDADE);
    localparam logic [AW:0] OCUP_CHEIO = (AW + 1)'(PROFUNDIDADE);
    localparam logic [AW:0] OCUP_UM    = (AW + 1)'(1);

    typedef enum logic [2:0] {OCIOSO, PEDE, DIRIGE, STROBE, LIBERA} estado_t;

    estado_t         estado, prox;
    logic [W-1:0]    mem [PROFUNDIDADE];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     cont;
    logic [W-1:0]    data_q;
    logic            drive_q, io_q, req_q;
    logic            push, pop;
    logic            req_d, io_d, drive_d;

    assign vazio     = (cont == '0);
    assign cheio     = (cont == OCUP_CHEIO);
    assign ocupacao  = cont;
    assign ula_ready = !cheio;
    assign push      = ula_valid && !cheio;
    assign pop       = (estado == LIBERA);

    assign bus_req = req_q;
    assign io      = io_q;
    assign Data    = drive_q ? data_q : {W{1'bz}};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= saidaUla;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cont   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cont <= cont + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:  if (!vazio) prox = PEDE;
            PEDE:    if (bus_grant) prox = DIRIGE;
            DIRIGE:  prox = STROBE;
            STROBE:  prox = LIBERA;
            LIBERA:  prox = (cont > OCUP_UM) ? PEDE : OCIOSO;
            default: prox = OCIOSO;
        endcase
        req_d   = (prox != OCIOSO);
        io_d    = (prox != STROBE);
        drive_d = (prox == DIRIGE) || (prox == STROBE) || (prox == LIBERA);
    end

    // Outputs are registered from the next state so they change exactly with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado  <= OCIOSO;
            req_q   <= 1'b0;
            io_q    <= 1'b1;
            drive_q <= 1'b0;
            data_q  <= '0;
        end else begin
            estado  <= prox;
            req_q   <= req_d;
            io_q    <= io_d;
            drive_q <= drive_d;
            if (prox == DIRIGE) data_q <= mem[rd_ptr];
        end
    end
endmodule
